// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core. An internal FSM sequences the rounds,
// either one sub-operation per clock or one fused round per clock, with
// valid/ready handshakes on the input and output sides.

// One S-box lane: GF(2^8) multiplicative inverse (as a^254) then the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, xa, yb;
    p  = '0;
    xa = x;
    yb = y;
    for (int i = 0; i < 8; i++) begin
      if (yb[0]) p = p ^ xa;
      xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
      yb = yb >> 1;
    end
    return p;
  endfunction

  logic [7:0] inv, pw;

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the inverse convention needs
  always_comb begin
    inv = 8'h01;
    pw  = a;
    for (int i = 1; i < 8; i++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_iter_core #(
  parameter int ROUND_PER_CYCLE = 0,
  parameter int ROUNDS          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] out_key,
  output logic         busy,
  output logic [7:0]   round_cnt
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam logic [7:0] LAST_RND = 8'(ROUNDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD0 = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_SHI  = 3'd3;
  localparam logic [2:0] S_MIX  = 3'd4;
  localparam logic [2:0] S_ADD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]   st_q;
  logic [127:0] blk_q, key_q;

  // byte 0 sits in [127:120]; columns are 4 consecutive bytes
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = x[127-32*c -: 32];
      y[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return y;
  endfunction

  function automatic logic [7:0] rcon(input logic [7:0] n);
    case (n)
      8'd1:    return 8'h01;
      8'd2:    return 8'h02;
      8'd3:    return 8'h04;
      8'd4:    return 8'h08;
      8'd5:    return 8'h10;
      8'd6:    return 8'h20;
      8'd7:    return 8'h40;
      8'd8:    return 8'h80;
      8'd9:    return 8'h1b;
      8'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [NUM_LANES-1:0][VEC_W-1:0] blk_l, sub_l;
  logic [3:0][VEC_W-1:0]           ksub;
  logic [31:0]                     rot_w, tw;
  logic [127:0]                    key_nx, sh_sub, fused, rnd_res, rnd_key;

  assign blk_l = blk_q;
  assign rot_w = {key_q[23:0], key_q[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_sub
      aes_sbox u_sb (.a(blk_l[gi]), .s(sub_l[gi]));
    end
    for (gi = 0; gi < 4; gi++) begin : g_ksub
      aes_sbox u_ksb (.a(rot_w[8*gi +: 8]), .s(ksub[gi]));
    end
  endgenerate

  // next round key from the current key and round index
  always_comb begin
    tw              = ksub ^ {rcon(round_cnt), 24'h0};
    key_nx[127:96]  = key_q[127:96] ^ tw;
    key_nx[95:64]   = key_q[95:64]  ^ key_nx[127:96];
    key_nx[63:32]   = key_q[63:32]  ^ key_nx[95:64];
    key_nx[31:0]    = key_q[31:0]   ^ key_nx[63:32];
  end

  // round result: fused round in per-round mode, plain AddRoundKey otherwise
  always_comb begin
    sh_sub  = shift_rows(sub_l);
    fused   = ((round_cnt == LAST_RND) ? sh_sub : mix_cols(sh_sub)) ^ key_nx;
    rnd_res = (ROUND_PER_CYCLE != 0) ? fused : (blk_q ^ key_q);
    rnd_key = (ROUND_PER_CYCLE != 0) ? key_nx : key_q;
  end

  assign in_ready = (st_q == S_IDLE);

  // round sequencer, datapath registers and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      blk_q     <= '0;
      key_q     <= '0;
      out_data  <= '0;
      out_key   <= '0;
      round_cnt <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: if (in_valid) begin
          blk_q     <= in_data;
          key_q     <= in_key;
          round_cnt <= 8'd1;
          busy      <= 1'b1;
          st_q      <= S_ADD0;
        end
        S_ADD0: begin
          blk_q <= blk_q ^ key_q;
          st_q  <= S_SUB;
        end
        S_SHI: begin
          blk_q <= shift_rows(blk_q);
          key_q <= key_nx;
          st_q  <= (round_cnt == LAST_RND) ? S_ADD : S_MIX;
        end
        S_MIX: begin
          blk_q <= mix_cols(blk_q);
          st_q  <= S_ADD;
        end
        S_SUB, S_ADD: begin
          if (st_q == S_SUB && ROUND_PER_CYCLE == 0) begin
            blk_q <= sub_l;
            st_q  <= S_SHI;
          end else begin
            blk_q <= rnd_res;
            key_q <= rnd_key;
            if (round_cnt == LAST_RND) begin
              out_data  <= rnd_res;
              out_key   <= rnd_key;
              out_valid <= 1'b1;
              st_q      <= S_DONE;
            end else begin
              round_cnt <= round_cnt + 8'd1;
              st_q      <= S_SUB;
            end
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          round_cnt <= '0;
          st_q      <= S_IDLE;
        end
        default: begin
          st_q      <= S_IDLE;
          out_data  <= '0;
          out_key   <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          round_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: one per-step and one per-round instance, checked
// against FIPS-197 vectors and a byte-array AES reference model.
module tb_aes_iter_core;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid [2];
  logic         in_ready [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         busy [2];
  logic [127:0] in_data [2];
  logic [127:0] in_key [2];
  logic [127:0] out_data [2];
  logic [127:0] out_key [2];
  logic [7:0]   round_cnt [2];
  int           total = 0;
  int           bad = 0;
  logic [7:0]   sb [256];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] lk;
  } vec_t;
  vec_t vt [2];

  always #5 clk = ~clk;

  aes_iter_core #(.ROUND_PER_CYCLE(0), .ROUNDS(10)) u_step (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_key(in_key[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_key(out_key[0]),
    .busy(busy[0]), .round_cnt(round_cnt[0]));

  aes_iter_core #(.ROUND_PER_CYCLE(1), .ROUNDS(10)) u_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_key(in_key[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_key(out_key[1]),
    .busy(busy[1]), .round_cnt(round_cnt[1]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input int a);
    logic [7:0] inv = 0;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic void aes_ref(input logic [127:0] pt, input logic [127:0] k,
                                  output logic [127:0] ct, output logic [127:0] lk);
    logic [7:0] s [16];
    logic [7:0] w [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc = 8'h01;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      w[i] = k[127-8*i -: 8];
      s[i] ^= w[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tmp[0] = sb[w[13]] ^ rc;
      tmp[1] = sb[w[14]];
      tmp[2] = sb[w[15]];
      tmp[3] = sb[w[12]];
      for (int j = 0; j < 4; j++) w[j] ^= tmp[j];
      for (int j = 4; j < 16; j++) w[j] ^= w[j-4];
      rc = gm(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[i];
    end
    for (int i = 0; i < 16; i++) begin
      ct[127-8*i -: 8] = s[i];
      lk[127-8*i -: 8] = w[i];
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 40 : 11;
  endfunction

  task automatic send(input int d, input logic [127:0] pt, input logic [127:0] k);
    int n = 0;
    while (!in_ready[d] && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready[d]) chk("send_ready_timeout", 128'(in_ready[d]), 128'd1);
    in_data[d] = pt; in_key[d] = k; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input int lat, input logic [127:0] ct,
                          input logic [127:0] lk, input string nm);
    int n = 0;
    while (!out_valid[d] && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, "_valid"}, 128'(out_valid[d]), 128'd1);
    if (lat >= 0) chk({nm, "_latency"}, 128'(n), 128'(lat));
    chk({nm, "_data"}, out_data[d], ct);
    chk({nm, "_key"}, out_key[d], lk);
  endtask

  task automatic handshake(input int d, input logic [127:0] ct, input string nm);
    @(posedge clk); #1;
    chk({nm, "_hs_flags"}, 128'({out_valid[d], in_ready[d], busy[d]}), 128'(3'b010));
    chk({nm, "_hs_rcnt"}, 128'(round_cnt[d]), 128'd0);
    chk({nm, "_hs_hold"}, out_data[d], ct);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] pt, k, ct, lk;
    int n;
    for (int a = 0; a < 256; a++) sb[a] = sbox_calc(a);
    vt[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; in_data[d] = '0; in_key[d] = '0;
    end

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_flags", d), 128'({in_ready[d], out_valid[d], busy[d]}), 128'(3'b100));
      chk($sformatf("rst%0d_rcnt", d), 128'(round_cnt[d]), 128'd0);
      chk($sformatf("rst%0d_odata", d), out_data[d], 128'd0);
      chk($sformatf("rst%0d_okey", d), out_key[d], 128'd0);
    end

    // FIPS-197 vectors on both sequencing modes
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 2; v++) begin
        send(d, vt[v].pt, vt[v].key);
        wait_out(d, lat_of(d), vt[v].ct, vt[v].lk, $sformatf("vec%0d_dut%0d", v, d));
        handshake(d, vt[v].ct, $sformatf("vec%0d_dut%0d", v, d));
      end

    // random blocks against the model
    for (int i = 0; i < 6; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      aes_ref(pt, k, ct, lk);
      for (int d = 0; d < 2; d++) begin
        send(d, pt, k);
        wait_out(d, lat_of(d), ct, lk, $sformatf("rnd%0d_dut%0d", i, d));
        handshake(d, ct, $sformatf("rnd%0d_dut%0d", i, d));
      end
    end

    // backpressure: result held while out_ready is low
    out_ready[0] = 1'b0;
    send(0, vt[0].pt, vt[0].key);
    wait_out(0, 40, vt[0].ct, vt[0].lk, "bp");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_flags%0d", i), 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b101));
      chk($sformatf("bp_hold_data%0d", i), out_data[0], vt[0].ct);
    end
    out_ready[0] = 1'b1;
    handshake(0, vt[0].ct, "bp");
    @(posedge clk); #1;
    chk("bp_single_hs", 128'(out_valid[0]), 128'd0);

    // input stall: offered block mid-operation is ignored
    send(0, vt[0].pt, vt[0].key);
    repeat (10) @(posedge clk);
    #1;
    in_data[0] = vt[1].pt; in_key[0] = vt[1].key; in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_ready%0d", i), 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    wait_out(0, -1, vt[0].ct, vt[0].lk, "stall");
    handshake(0, vt[0].ct, "stall");
    send(0, vt[0].pt, vt[0].key);
    wait_out(0, 40, vt[0].ct, vt[0].lk, "b2b_a");
    handshake(0, vt[0].ct, "b2b_a");
    send(0, vt[1].pt, vt[1].key);
    wait_out(0, 40, vt[1].ct, vt[1].lk, "b2b_b");
    handshake(0, vt[1].ct, "b2b_b");

    // reset mid-operation at round 5
    send(0, vt[0].pt, vt[0].key);
    n = 0;
    while (round_cnt[0] != 8'd5 && n < 100) begin @(posedge clk); #1; n++; end
    chk("mrst_reach5", 128'(round_cnt[0]), 128'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_flags", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b001));
    chk("mrst_rcnt", 128'(round_cnt[0]), 128'd0);
    chk("mrst_odata", out_data[0], 128'd0);
    send(0, vt[0].pt, vt[0].key);
    wait_out(0, 40, vt[0].ct, vt[0].lk, "mrst_fresh");
    handshake(0, vt[0].ct, "mrst_fresh");

    // round_cnt trace: rounds of 4 steps (SUB SHI MIX ADD), last one 3
    send(0, vt[0].pt, vt[0].key);
    chk("trace_t0", 128'(round_cnt[0]), 128'd1);
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      n = 1 + (t - 1) / 4;
      if (n > 10) n = 10;
      chk($sformatf("trace_t%0d", t), 128'(round_cnt[0]), 128'(n));
    end
    chk("trace_done_valid", 128'(out_valid[0]), 128'd1);
    chk("trace_done_data", out_data[0], vt[0].ct);
    handshake(0, vt[0].ct, "trace");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Self-sequencing iterative AES-128 encryption core.
- It sequences rounds with an internal FSM instead of an external state bus, and uses a valid/ready handshake on both sides.
- Reuses the team's existing combinational cells: addRoundKey, subBytes128, shift128, mixCol128, expandKey.
- Parametrised for per-step or per-round sequencing, and for round count. It sits between the block-buffer front end and the cipher output FIFO.

Parameters:
- ROUND_PER_CYCLE, 0: 0 = one sub-operation per clock (ADD/SUB/SHI/MIX); 1 = full round per clock (SUB→SHI→MIX→ADD chained combinationally).
- ROUNDS, 10: number of cipher rounds, legal range 1..10. The last round omits MixColumns. Reduced values are for debug only.

Ports:
- clk  in  1: single clock; all state updates on posedge.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: plaintext/key offered.
- in_ready  out  1: core can accept a block.
- in_data  in  128: plaintext block, byte 0 in [127:120].
- in_key  in  128: cipher key, same byte order.
- out_valid  out  1: ciphertext available.
- out_ready  in  1: consumer accepts ciphertext.
- out_data  out  128: ciphertext.
- out_key  out  128: last round key, for handing to a decrypt core.
- busy  out  1: high from accept until the out handshake completes.
- round_cnt  out  8: current round index, 0..ROUNDS; drives the expandKey count input.

Behaviour:
- Synchronous reset when rst_n=0 at posedge:
  - state=IDLE.
  - state/key/out_data/out_key registers = 0.
  - round_cnt=0, out_valid=0, busy=0.
  - Then in_ready=1 from the first cycle after release.
  - Reset mid-operation aborts the block silently; no output is produced.
- FSM states: IDLE, ADD0, SUB, SHI, MIX, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data→state, in_key→key, round_cnt←1, busy←1, go to ADD0.
  - in_valid while not in IDLE is ignored; the input is not consumed.
- ADD0: state←state^key (initial AddRoundKey).
  - ROUND_PER_CYCLE=0: go to SUB.
  - ROUND_PER_CYCLE=1: go to the fused round step, which stays in SUB encoding.
- ROUND_PER_CYCLE=0 sequence:
  - SUB: state←SubBytes(state).
  - SHI: state←ShiftRows(state); key←expandKey(key, round_cnt).
  - If round_cnt<ROUNDS: MIX (state←MixColumns), then ADD. Otherwise go directly to ADD.
  - ADD: state←state^key.
    - If round_cnt==ROUNDS, go to DONE.
    - Otherwise round_cnt←round_cnt+1 and go to SUB.
- ROUND_PER_CYCLE=1:
  - One cycle per round: state←AddRoundKey(Mix?(Shift(Sub(state))), expandKey(key,round_cnt)); key←expandKey(key,round_cnt).
  - Mix is bypassed when round_cnt==ROUNDS.
  - Increment/exit rules are the same as ADD above.
- Latency, counting posedges after the accepting edge until out_valid is high:
  - ROUND_PER_CYCLE=0: 1 + 4·(ROUNDS−1) + 3 = 40 for ROUNDS=10.
  - ROUND_PER_CYCLE=1: 1 + ROUNDS = 11.
- Entering DONE:
  - out_data←state, out_key←key, out_valid←1, in_ready=0.
  - out_data and out_key are held stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid←0, busy←0, round_cnt←0, go to IDLE. The next accept is possible on the following edge.
- No overlap between blocks: throughput is one block per latency+2 cycles minimum.
- out_data and out_key retain their last value after handshake until the next DONE.
- round_cnt never exceeds ROUNDS and never wraps.
- No X assignment in any state; an illegal state encoding returns to IDLE with outputs cleared.
- in_ready is combinational from state only; it has no path from in_valid or out_ready.

Test Plan:
- FIPS-197 App. B, default params:
  - Stimulus: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32 and out_key=d014f9a8c9ee2589e13f0cc8b6630ca6, with out_valid first high exactly 40 posedges after accept.
- FIPS-197 App. C.1, ROUND_PER_CYCLE=1:
  - Stimulus: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid 11 posedges after accept.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out_data/out_valid stable, in_ready=0, busy=1. Then release: a single handshake, and in_ready=1 the next cycle.
- Input stall: pulse in_valid with a different block mid-operation. Required: the block is not consumed and the first result is unaffected. Then back-to-back App. B and C.1 blocks both give correct results in order.
- Reset mid-operation: rst_n=0 for 1 cycle at round_cnt=5. Required: the next cycle shows out_valid=0, busy=0, round_cnt=0, out_data=0, in_ready=1, and a fresh App. B block then gives the correct result.
- round_cnt trace: with default params, round_cnt steps 1..10, changing only on ADD exits. It reads 10 in DONE and 0 after the handshake.
